// File: rtl/mem_stage.sv
// Memory-bus stage: issues data-memory loads/stores, extracts load data,
// raises misalignment traps and registers the writeback bundle.
module mem_stage #(
    parameter logic [31:0] RESET_PC_TAG = 32'hffffffff
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_flush,
    input  logic [31:0] ex_mb__alu_y,
    input  logic [31:0] ex_mb__rs2_rdata,
    input  logic [31:0] ex_mb__pc,
    input  logic [31:0] ex_mb__pc_4,
    input  logic [31:0] ex_mb__csr_rdata,
    input  logic [4:0]  ex_mb__rd_addr,
    input  logic        ex_mb__rd_wen,
    input  logic        ex_mb__mem_read,
    input  logic        ex_mb__mem_write,
    input  logic [2:0]  ex_mb__mem_funct3,
    input  logic [1:0]  ex_mb__rd_src,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_req_addr,
    output logic        dmem_req_we,
    output logic [3:0]  dmem_req_wstrb,
    output logic [31:0] dmem_req_wdata,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_rdata,
    output logic        mb_stall,
    output logic        mb_if__trap_taken,
    output logic [4:0]  mb_ex__trap_src,
    output logic [31:0] mb_ex__dmem_addr,
    output logic        mb_ex__instret,
    output logic [4:0]  mb_wb__rd_addr,
    output logic        mb_wb__rd_wen,
    output logic [31:0] mb_wb__rd_wdata,
    output logic [1:0]  dbg_state
);

    // Request channel: dmem_req_valid high means addr/we/wstrb/wdata are valid and
    // held stable until the cycle dmem_req_ready is also high (transfer on that edge).
    // Response channel is valid-only: data is taken in any cycle dmem_rsp_valid is high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;
    logic [3:0]  req_wstrb_q;
    logic        req_we_q;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic        flushed_q;

    logic        valid;
    logic        mem_op;
    logic        misaligned;
    logic        trap_now;
    logic        kill;
    logic [3:0]  store_wstrb;
    logic [31:0] store_wdata;
    logic [31:0] rsp_shifted;
    logic [31:0] load_data;
    logic [31:0] wb_data;

    assign valid  = (ex_mb__pc != RESET_PC_TAG);
    assign mem_op = valid && (ex_mb__mem_read || ex_mb__mem_write);

    always_comb begin
        misaligned = 1'b0;
        case (ex_mb__mem_funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = ex_mb__alu_y[0];
            default: misaligned = (ex_mb__alu_y[1:0] != 2'b00);
        endcase
        misaligned = misaligned && mem_op;
    end

    assign trap_now = (state == IDLE) && misaligned && !pipe_flush;

    always_comb begin
        store_wstrb = 4'b1111;
        store_wdata = ex_mb__rs2_rdata;
        case (ex_mb__mem_funct3[1:0])
            2'b00: begin
                store_wstrb = 4'b0001 << ex_mb__alu_y[1:0];
                store_wdata = {4{ex_mb__rs2_rdata[7:0]}};
            end
            2'b01: begin
                store_wstrb = 4'b0011 << ex_mb__alu_y[1:0];
                store_wdata = {2{ex_mb__rs2_rdata[15:0]}};
            end
            default: begin
                store_wstrb = 4'b1111;
                store_wdata = ex_mb__rs2_rdata;
            end
        endcase
    end

    assign rsp_shifted = dmem_rsp_rdata >> {off_q, 3'b000};

    always_comb begin
        load_data = rsp_shifted;
        case (funct3_q)
            3'b000:  load_data = {{24{rsp_shifted[7]}}, rsp_shifted[7:0]};
            3'b100:  load_data = {24'd0, rsp_shifted[7:0]};
            3'b001:  load_data = {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
            3'b101:  load_data = {16'd0, rsp_shifted[15:0]};
            default: load_data = rsp_shifted;
        endcase
    end

    always_comb begin
        wb_data = ex_mb__alu_y;
        case (ex_mb__rd_src)
            2'd0: wb_data = ex_mb__alu_y;
            2'd1: wb_data = ex_mb__pc_4;
            2'd2: wb_data = ex_mb__csr_rdata;
            2'd3: wb_data = load_data;
        endcase
    end

    always_comb begin
        mb_stall = 1'b0;
        kill     = 1'b0;
        case (state)
            IDLE: begin
                mb_stall = mem_op && !misaligned && !pipe_flush;
                kill     = !valid || pipe_flush || misaligned;
            end
            REQ: begin
                mb_stall = !(dmem_req_ready && req_we_q);
                kill     = flushed_q || pipe_flush;
            end
            RSP: begin
                mb_stall = !dmem_rsp_valid;
                kill     = flushed_q || pipe_flush;
            end
            default: begin
                mb_stall = 1'b0;
                kill     = 1'b1;
            end
        endcase
    end

    assign dmem_req_valid = (state == REQ);
    assign dmem_req_addr  = req_addr_q;
    assign dmem_req_we    = req_we_q;
    assign dmem_req_wstrb = req_wstrb_q;
    assign dmem_req_wdata = req_wdata_q;
    assign dbg_state      = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            req_addr_q        <= '0;
            req_wdata_q       <= '0;
            req_wstrb_q       <= '0;
            req_we_q          <= 1'b0;
            off_q             <= '0;
            funct3_q          <= '0;
            flushed_q         <= 1'b0;
            mb_if__trap_taken <= 1'b0;
            mb_ex__trap_src   <= '0;
            mb_ex__dmem_addr  <= '0;
            mb_ex__instret    <= 1'b0;
            mb_wb__rd_addr    <= '0;
            mb_wb__rd_wen     <= 1'b0;
            mb_wb__rd_wdata   <= '0;
        end else begin
            mb_if__trap_taken <= 1'b0;
            mb_ex__instret    <= 1'b0;

            // Any unstalled cycle is the completion of the slot in mb.
            if (!mb_stall) begin
                mb_wb__rd_addr  <= ex_mb__rd_addr;
                mb_wb__rd_wen   <= ex_mb__rd_wen && !kill;
                mb_wb__rd_wdata <= wb_data;
                mb_ex__instret  <= !kill;
            end

            if (trap_now) begin
                mb_if__trap_taken <= 1'b1;
                mb_ex__trap_src   <= ex_mb__mem_read ? 5'd4 : 5'd6;
                mb_ex__dmem_addr  <= ex_mb__alu_y;
            end

            case (state)
                IDLE: begin
                    flushed_q <= 1'b0;
                    if (mb_stall) begin
                        req_addr_q  <= {ex_mb__alu_y[31:2], 2'b00};
                        req_we_q    <= ex_mb__mem_write;
                        req_wstrb_q <= ex_mb__mem_write ? store_wstrb : 4'b0000;
                        req_wdata_q <= ex_mb__mem_write ? store_wdata : 32'd0;
                        off_q       <= ex_mb__alu_y[1:0];
                        funct3_q    <= ex_mb__mem_funct3;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (pipe_flush) flushed_q <= 1'b1;
                    if (dmem_req_ready) begin
                        if (req_we_q) begin
                            flushed_q <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            state <= RSP;
                        end
                    end
                end
                RSP: begin
                    if (pipe_flush) flushed_q <= 1'b1;
                    if (dmem_rsp_valid) begin
                        flushed_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus random instruction stream,
// a bus responder driven per instruction and a queue-based completion monitor.
module tb_mem_stage;

    localparam logic [31:0] TAG = 32'hffffffff;

    typedef struct packed {
        logic [7:0]  lat;
        logic        instret;
        logic        trap;
        logic [4:0]  src;
        logic [31:0] daddr;
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_t;

    logic        clk, rst_n, pipe_flush;
    logic [31:0] ex_mb__alu_y, ex_mb__rs2_rdata, ex_mb__pc, ex_mb__pc_4, ex_mb__csr_rdata;
    logic [4:0]  ex_mb__rd_addr;
    logic        ex_mb__rd_wen, ex_mb__mem_read, ex_mb__mem_write;
    logic [2:0]  ex_mb__mem_funct3;
    logic [1:0]  ex_mb__rd_src;
    logic        dmem_req_valid, dmem_req_ready, dmem_req_we, dmem_rsp_valid;
    logic [31:0] dmem_req_addr, dmem_req_wdata, dmem_rsp_rdata;
    logic [3:0]  dmem_req_wstrb;
    logic        mb_stall, mb_if__trap_taken, mb_ex__instret, mb_wb__rd_wen;
    logic [4:0]  mb_ex__trap_src, mb_wb__rd_addr;
    logic [31:0] mb_ex__dmem_addr, mb_wb__rd_wdata;
    logic [1:0]  dbg_state;

    exp_t exp_q[$];
    bus_t bus_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   stall_cnt = 0;
    logic mon_en = 1'b0;
    logic abort = 1'b0;

    mem_stage #(.RESET_PC_TAG(TAG)) dut (
        .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
        .ex_mb__alu_y(ex_mb__alu_y), .ex_mb__rs2_rdata(ex_mb__rs2_rdata),
        .ex_mb__pc(ex_mb__pc), .ex_mb__pc_4(ex_mb__pc_4), .ex_mb__csr_rdata(ex_mb__csr_rdata),
        .ex_mb__rd_addr(ex_mb__rd_addr), .ex_mb__rd_wen(ex_mb__rd_wen),
        .ex_mb__mem_read(ex_mb__mem_read), .ex_mb__mem_write(ex_mb__mem_write),
        .ex_mb__mem_funct3(ex_mb__mem_funct3), .ex_mb__rd_src(ex_mb__rd_src),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_addr(dmem_req_addr), .dmem_req_we(dmem_req_we),
        .dmem_req_wstrb(dmem_req_wstrb), .dmem_req_wdata(dmem_req_wdata),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
        .mb_stall(mb_stall), .mb_if__trap_taken(mb_if__trap_taken),
        .mb_ex__trap_src(mb_ex__trap_src), .mb_ex__dmem_addr(mb_ex__dmem_addr),
        .mb_ex__instret(mb_ex__instret), .mb_wb__rd_addr(mb_wb__rd_addr),
        .mb_wb__rd_wen(mb_wb__rd_wen), .mb_wb__rd_wdata(mb_wb__rd_wdata),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic is_mis(input logic [2:0] f3, input logic [31:0] a);
        return (a % acc_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] word, input logic [1:0] o,
                                             input logic [2:0] f3);
        logic [31:0] v;
        v = word >> (8 * o);
        case (f3)
            3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'd4: v = v % 256;
            3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'd5: v = v % 65536;
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic bus_t bus_model(input logic [31:0] a, input logic [31:0] rs2,
                                       input logic mw, input logic [2:0] f3);
        bus_t b;
        int   sz, o;
        sz = acc_size(f3);
        o  = int'(a % 4);
        b.addr  = a - (a % 4);
        b.we    = mw;
        b.wstrb = '0;
        b.wdata = '0;
        for (int i = 0; i < 4; i++) begin
            if (mw && i >= o && i < o + sz) b.wstrb[i] = 1'b1;
            b.wdata[8*i +: 8] = rs2[8*(i % sz) +: 8];
        end
        return b;
    endfunction

    function automatic int nominal_lat(input logic memop, input logic mis, input logic mw,
                                       input int rdly, input int rspdly);
        if (!memop || mis) return 0;
        return mw ? 1 + rdly : 2 + rdly + rspdly;
    endfunction

    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] a,
                                   input logic [31:0] pc4, input logic [31:0] csr,
                                   input logic [4:0] rd, input logic rdwen, input logic mr,
                                   input logic mw, input logic [2:0] f3, input logic [1:0] src,
                                   input int rdly, input int rspdly, input int flush_at,
                                   input logic [31:0] rsp_word);
        exp_t e;
        logic valid, memop, mis, killed;
        valid  = (pc != TAG);
        memop  = valid && (mr || mw);
        mis    = memop && is_mis(f3, a);
        killed = !valid || (flush_at >= 0);
        e = '0;
        e.rd = rd;
        if (memop && flush_at == 0) begin
            e.lat = 0;
        end else if (mis) begin
            e.lat   = 0;
            e.trap  = 1'b1;
            e.src   = mr ? 5'd4 : 5'd6;
            e.daddr = a;
            killed  = 1'b1;
        end else begin
            e.lat = 8'(nominal_lat(memop, mis, mw, rdly, rspdly));
        end
        e.instret = !killed;
        e.wen     = rdwen && !killed;
        case (src)
            2'd0: e.wdata = a;
            2'd1: e.wdata = pc4;
            2'd2: e.wdata = csr;
            default: e.wdata = load_val(rsp_word, a[1:0], f3);
        endcase
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic run_instr(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] rs2,
                             input logic [4:0] rd, input logic rdwen, input logic mr,
                             input logic mw, input logic [2:0] f3, input logic [1:0] src,
                             input int rdly, input int rspdly, input int flush_at,
                             input logic [31:0] rsp_word);
        int   cyc, rc, sc;
        logic accepted, done;
        ex_mb__pc = pc;        ex_mb__alu_y = a;       ex_mb__rs2_rdata = rs2;
        ex_mb__pc_4 = pc + 4;  ex_mb__csr_rdata = $urandom;
        ex_mb__rd_addr = rd;   ex_mb__rd_wen = rdwen;
        ex_mb__mem_read = mr;  ex_mb__mem_write = mw;
        ex_mb__mem_funct3 = f3; ex_mb__rd_src = src;
        exp_q.push_back(model(pc, a, ex_mb__pc_4, ex_mb__csr_rdata, rd, rdwen, mr, mw, f3, src,
                              rdly, rspdly, flush_at, rsp_word));
        if (pc != TAG && (mr || mw) && !is_mis(f3, a) && flush_at != 0)
            bus_q.push_back(bus_model(a, rs2, mw, f3));
        cyc = 0; rc = 0; sc = 0; accepted = 1'b0; done = 1'b0;
        while (!done) begin
            pipe_flush     = (cyc == flush_at);
            dmem_req_ready = 1'b0;
            dmem_rsp_valid = 1'b0;
            dmem_rsp_rdata = $urandom;
            if (dmem_req_valid) begin
                if (rc >= rdly) begin dmem_req_ready = 1'b1; accepted = 1'b1; end
                else rc++;
            end else if (accepted && mr) begin
                if (sc >= rspdly) begin dmem_rsp_valid = 1'b1; dmem_rsp_rdata = rsp_word; end
                else sc++;
            end
            @(negedge clk);
            done = !mb_stall;
            @(posedge clk);
            #2;
            cyc++;
            if (!done && cyc > 64) begin
                check("completion_timeout", 32'(cyc), 32'd64);
                done  = 1'b1;
                abort = 1'b1;
            end
        end
        pipe_flush = 1'b0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    endtask

    task automatic drive_bubble();
        ex_mb__pc = TAG; ex_mb__alu_y = '0; ex_mb__rs2_rdata = '0; ex_mb__pc_4 = '0;
        ex_mb__csr_rdata = '0; ex_mb__rd_addr = '0; ex_mb__rd_wen = 1'b0;
        ex_mb__mem_read = 1'b0; ex_mb__mem_write = 1'b0; ex_mb__mem_funct3 = '0;
        ex_mb__rd_src = '0; pipe_flush = 1'b0; dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0;
    endtask

    // ---------------- monitors / scoreboard ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!mon_en || !rst_n) begin
                stall_cnt = 0;
            end else if (mb_stall) begin
                stall_cnt++;
                @(posedge clk); #1;
                check("pulse_instret_low", 32'(mb_ex__instret), 32'd0);
                check("pulse_trap_low", 32'(mb_if__trap_taken), 32'd0);
            end else begin
                @(posedge clk); #1;
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("stall_cycles", 32'(stall_cnt), 32'(e.lat));
                    check("instret", 32'(mb_ex__instret), 32'(e.instret));
                    check("trap_taken", 32'(mb_if__trap_taken), 32'(e.trap));
                    if (e.trap) begin
                        check("trap_src", 32'(mb_ex__trap_src), 32'(e.src));
                        check("trap_addr", mb_ex__dmem_addr, e.daddr);
                    end
                    check("rd_wen", 32'(mb_wb__rd_wen), 32'(e.wen));
                    if (e.wen) begin
                        check("rd_addr", 32'(mb_wb__rd_addr), 32'(e.rd));
                        check("rd_wdata", mb_wb__rd_wdata, e.wdata);
                    end
                    check("req_valid_idle", 32'(dmem_req_valid), 32'd0);
                end
                stall_cnt = 0;
            end
        end
    end

    initial begin
        bus_t b;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && dmem_req_valid) begin
                if (bus_q.size() == 0) begin
                    check("unexpected_request", 32'd1, 32'd0);
                end else begin
                    b = bus_q[0];
                    check("req_addr", dmem_req_addr, b.addr);
                    check("req_we", 32'(dmem_req_we), 32'(b.we));
                    check("req_wstrb", 32'(dmem_req_wstrb), 32'(b.wstrb));
                    if (b.we) check("req_wdata", dmem_req_wdata, b.wdata);
                    if (dmem_req_ready) void'(bus_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int          kind, rdly, rspdly, flush_at, lat;
        logic [31:0] pc, a;
        logic        mr, mw, rdwen;
        logic [2:0]  f3;
        logic [1:0]  src;
        logic [2:0]  ld_f3 [5];
        ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;

        rst_n = 1'b0;
        drive_bubble();
        repeat (3) @(posedge clk);
        #2;
        check("reset_req_valid", 32'(dmem_req_valid), 32'd0);
        check("reset_rd_wen", 32'(mb_wb__rd_wen), 32'd0);
        check("reset_trap_src", 32'(mb_ex__trap_src), 32'd0);
        check("reset_instret", 32'(mb_ex__instret), 32'd0);
        check("reset_rd_wdata", mb_wb__rd_wdata, 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // LB sign-extended from top byte; SH to upper half; misaligned LW trap
        run_instr(32'h1000, 32'h103, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 3'd0, 2'd3, 0, 0, -1, 32'h80AABBCC);
        run_instr(32'h1004, 32'h202, 32'h1234, 5'd0, 1'b0, 1'b0, 1'b1, 3'd1, 2'd0, 0, 0, -1, 32'h0);
        run_instr(32'h1008, 32'h301, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'd2, 2'd3, 0, 0, -1, 32'h0);
        // LW with slow ready, then LW flushed while waiting for its response
        run_instr(32'h100c, 32'h500, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'd2, 2'd3, 3, 1, -1, 32'hDEADBEEF);
        run_instr(32'h1010, 32'h504, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 3'd2, 2'd3, 0, 2, 2, 32'h12345678);
        // misaligned store flushed in the same cycle: no trap
        run_instr(32'h1014, 32'h603, 32'h55, 5'd0, 1'b0, 1'b0, 1'b1, 3'd2, 2'd0, 0, 0, 0, 32'h0);
        mon_en = 1'b0;

        // reset while a request is pending
        ex_mb__pc = 32'h2000; ex_mb__alu_y = 32'h400; ex_mb__mem_read = 1'b1;
        ex_mb__mem_funct3 = 3'd2; ex_mb__rd_src = 2'd3; ex_mb__rd_wen = 1'b1; ex_mb__rd_addr = 5'd9;
        dmem_req_ready = 1'b0;
        @(posedge clk); #2;
        check("pre_reset_req_valid", 32'(dmem_req_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_req_valid", 32'(dmem_req_valid), 32'd0);
        check("async_reset_req_addr", dmem_req_addr, 32'd0);
        check("async_reset_rd_wdata", mb_wb__rd_wdata, 32'd0);
        check("async_reset_rd_addr", 32'(mb_wb__rd_addr), 32'd0);
        check("async_reset_dmem_addr", mb_ex__dmem_addr, 32'd0);
        drive_bubble();
        @(posedge clk); #2;
        rst_n = 1'b1;
        exp_q.delete();
        bus_q.delete();
        mon_en = 1'b1;
        run_instr(32'h3000, 32'd7, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 0, 0, -1, 32'h0);

        for (int n = 0; n < 300 && !abort; n++) begin
            kind  = $urandom_range(0, 9);
            pc    = $urandom & 32'hfffffffc;
            a     = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            rdwen = 1'($urandom_range(0, 1));
            mr = 1'b0; mw = 1'b0;
            f3  = 3'($urandom_range(0, 7));
            src = 2'($urandom_range(0, 2));
            if (kind == 0) begin
                pc = TAG; mr = 1'($urandom_range(0, 1)); mw = !mr;
            end else if (kind >= 4 && kind <= 6) begin
                mr = 1'b1; f3 = ld_f3[$urandom_range(0, 4)]; src = 2'd3;
            end else if (kind >= 7) begin
                mw = 1'b1; f3 = 3'($urandom_range(0, 2)); rdwen = 1'b0;
            end
            rdly   = $urandom_range(0, 3);
            rspdly = $urandom_range(0, 3);
            lat    = nominal_lat(pc != TAG && (mr || mw), is_mis(f3, a), mw, rdly, rspdly);
            flush_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, lat) : -1;
            run_instr(pc, a, $urandom, 5'($urandom), rdwen, mr, mw, f3, src, rdly, rspdly,
                      flush_at, $urandom);
        end

        mon_en = 1'b0;
        drive_bubble();
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
